// File: rtl/kosei_audio_pkg.sv
// Shared audio types: sample width, default oversampling, feeder FSM states
// and the stereo word carried through the sample FIFO.
package kosei_audio_pkg;

  localparam int SAMPLE_W     = 24;
  localparam int OSR_LOG2_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } feed_state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } stereo_t;

  // Clamp a (SAMPLE_W+1)-bit signed value into SAMPLE_W-bit signed range.
  function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [SAMPLE_W:0] x);
    if (x[SAMPLE_W] != x[SAMPLE_W-1])
      return x[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    return x[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/interp_feeder_if.sv
// Sample-rate input handshake and clk-rate interpolated output stream.
interface interp_feeder_if;
  import kosei_audio_pkg::*;

  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_l;
  logic [SAMPLE_W-1:0] s_r;
  logic                out_valid;
  logic [SAMPLE_W-1:0] out_l;
  logic [SAMPLE_W-1:0] out_r;

  modport master (output s_valid, s_l, s_r, input s_ready, out_valid, out_l, out_r);
  modport slave  (input s_valid, s_l, s_r, output s_ready, out_valid, out_l, out_r);

endinterface

// File: rtl/interp_feeder_fifo.sv
// First-word-fall-through stereo sample FIFO with a registered ready that
// tracks the post-update occupancy, so it is low exactly while full.
module sample_fifo #(
  parameter  int W     = 48,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic          ready,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_nxt;

  assign level_nxt = level + LW'(push) - LW'(pop);
  assign empty     = (level == '0);
  assign rdata     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      ready <= (level_nxt != LW'(DEPTH));
    end
  end

endmodule

// File: rtl/interp_feeder.sv
// Linear-interpolating upsampler: buffers stereo samples and ramps between
// consecutive endpoints over 2**OSR_LOG2 clk cycles, holding on underrun.
module interp_feeder
  import kosei_audio_pkg::*;
#(
  parameter  int OSR_LOG2   = OSR_LOG2_DEF,
  parameter  int FIFO_DEPTH = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  interp_feeder_if.slave   bus,
  output logic             underrun,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int NUM_CH = 2;
  localparam int DLT_W  = SAMPLE_W + 1;
  localparam int ACC_W  = SAMPLE_W + 1 + OSR_LOG2;

  stereo_t wr_s, rd_s;
  logic    fifo_empty, fifo_rdy, push, pop;

  assign wr_s          = '{l: bus.s_l, r: bus.s_r};
  assign push          = bus.s_valid & fifo_rdy;
  assign bus.s_ready   = fifo_rdy;

  sample_fifo #(.W($bits(stereo_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_s),
    .pop   (pop),
    .rdata (rd_s),
    .empty (fifo_empty),
    .ready (fifo_rdy),
    .level (fifo_level)
  );

  feed_state_e         state;
  logic [OSR_LOG2-1:0] phase;
  logic                out_vld;
  logic                seg_end, c_first, c_seg, c_hold, c_step;

  // A new segment starts from PRIME, from HOLD, or at the last phase of RUN.
  assign seg_end = (state == ST_RUN) && (phase == '1);
  assign c_first = (state == ST_IDLE) && !fifo_empty;
  assign c_seg   = !fifo_empty && ((state == ST_PRIME) || (state == ST_HOLD) || seg_end);
  assign c_hold  = seg_end && fifo_empty;
  assign c_step  = (state == ST_RUN) && !seg_end;
  assign pop     = c_first | c_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      phase    <= '0;
      out_vld  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:  if (!fifo_empty) state <= ST_PRIME;
        ST_PRIME: if (!fifo_empty) begin
          state   <= ST_RUN;
          phase   <= '0;
          out_vld <= 1'b1;
        end
        ST_RUN: begin
          phase <= phase + 1'b1;
          if (c_hold) begin
            state    <= ST_HOLD;
            underrun <= 1'b1;
          end
        end
        ST_HOLD:  if (!fifo_empty) begin
          state <= ST_RUN;
          phase <= '0;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  logic [NUM_CH-1:0][SAMPLE_W-1:0] head_ch, out_ch;
  assign head_ch = {rd_s.r, rd_s.l};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [SAMPLE_W-1:0] head, cur;
    logic signed [DLT_W-1:0]    delta;
    logic signed [ACC_W-1:0]    acc;

    assign head = head_ch[c];

    // Reloading acc from the endpoint each segment keeps rounding from drifting.
    always_ff @(posedge clk) begin
      if (rst) begin
        cur   <= '0;
        delta <= '0;
        acc   <= '0;
      end else if (c_first) begin
        cur <= head;
      end else if (c_seg) begin
        acc   <= ACC_W'(cur) <<< OSR_LOG2;
        delta <= DLT_W'(head) - DLT_W'(cur);
        cur   <= head;
      end else if (c_hold) begin
        acc   <= ACC_W'(cur) <<< OSR_LOG2;
        delta <= '0;
      end else if (c_step) begin
        acc <= acc + ACC_W'(delta);
      end
    end

    assign out_ch[c] = sat_sample(acc[ACC_W-1:OSR_LOG2]);
  end

  assign bus.out_valid = out_vld;
  assign bus.out_l     = out_ch[0];
  assign bus.out_r     = out_ch[1];

endmodule

// File: tb/tb_interp_feeder.sv
// Scoreboard bench for interp_feeder at OSR_LOG2=2, FIFO_DEPTH=4.
module tb_interp_feeder;

  localparam int OSR_LOG2 = 2;
  localparam int OSR      = 1 << OSR_LOG2;
  localparam int DEPTH    = 4;

  typedef struct { int l; int r; } smp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       underrun;
  logic [2:0] fifo_level;

  interp_feeder_if bus();

  interp_feeder #(.OSR_LOG2(OSR_LOG2), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  smp_t sb[$];
  smp_t last_in, hold_v, mon_e;
  bit   have_prev = 0;
  bit   hold_mode = 0;
  int   mon_l, mon_r;

  function automatic longint fdiv(longint a, longint b);
    longint q = a / b;
    if ((a % b != 0) && (a < 0)) q--;
    return q;
  endfunction

  // Each accepted sample after the first closes a segment of OSR outputs.
  task automatic model_push(input int l, input int r);
    if (have_prev)
      for (int k = 0; k < OSR; k++)
        sb.push_back('{l: last_in.l + int'(fdiv(longint'(k) * (l - last_in.l), OSR)),
                       r: last_in.r + int'(fdiv(longint'(k) * (r - last_in.r), OSR))});
    have_prev = 1;
    last_in   = '{l: l, r: r};
  endtask

  // Output monitor; an empty queue with valid output means the DUT should be holding.
  always @(posedge clk) begin
    #1;
    if (!rst && bus.out_valid) begin
      mon_l = $signed(bus.out_l);
      mon_r = $signed(bus.out_r);
      if (!hold_mode && sb.size() == 0) begin
        hold_mode = 1;
        hold_v    = last_in;
      end
      if (hold_mode && mon_l == hold_v.l && mon_r == hold_v.r) begin
        checks++;
        if (underrun !== 1'b1) begin
          errors++;
          $display("FAIL hold_underrun got %b exp 1", underrun);
        end
      end else begin
        if (hold_mode) begin
          while (sb.size() > 0 && sb[0].l == hold_v.l && sb[0].r == hold_v.r) void'(sb.pop_front());
          hold_mode = 0;
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stream_extra got l=%0d r=%0d exp nothing", mon_l, mon_r);
        end else begin
          mon_e = sb.pop_front();
          if (mon_l != mon_e.l || mon_r != mon_e.r) begin
            errors++;
            $display("FAIL stream got l=%0d r=%0d exp l=%0d r=%0d", mon_l, mon_r, mon_e.l, mon_e.r);
          end
        end
      end
    end
  end

  task automatic clear_model();
    sb.delete();
    hold_mode = 0;
    have_prev = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.s_valid = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input int l, input int r);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_l = 24'(l);
    bus.s_r = 24'(r);
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout got s_ready=0 exp 1 within 200 cycles");
    end else begin
      model_push(l, r);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.s_ready !== 1'b0)   begin errors++; $display("FAIL reset_s_ready got %b exp 0", bus.s_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_l !== 24'd0)    begin errors++; $display("FAIL reset_out_l got %0d exp 0", bus.out_l); end
    checks++; if (bus.out_r !== 24'd0)    begin errors++; $display("FAIL reset_out_r got %0d exp 0", bus.out_r); end
    checks++; if (fifo_level !== 3'd0)    begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (underrun !== 1'b0)      begin errors++; $display("FAIL reset_underrun got %b exp 0", underrun); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.s_ready !== 1'b1)   begin errors++; $display("FAIL post_reset_s_ready got %b exp 1", bus.s_ready); end
  endtask

  task automatic test_ramp_hold();
    do_reset();
    send(0, 0);
    send(400, -400);
    send(400, -400);
    repeat (20) @(negedge clk);
    checks++; if (sb.size() != 0)  begin errors++; $display("FAIL ramp_drain got %0d left exp 0", sb.size()); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ramp_underrun got %b exp 1", underrun); end
    checks++; if ($signed(bus.out_l) != 400) begin errors++; $display("FAIL ramp_hold_l got %0d exp 400", $signed(bus.out_l)); end
  endtask

  task automatic test_resume();
    send(800, -800);
    repeat (14) @(negedge clk);
    checks++; if (sb.size() != 0)  begin errors++; $display("FAIL resume_drain got %0d left exp 0", sb.size()); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL resume_underrun got %b exp 1", underrun); end
    checks++; if ($signed(bus.out_r) != -800) begin errors++; $display("FAIL resume_hold_r got %0d exp -800", $signed(bus.out_r)); end
  endtask

  task automatic test_full_swing();
    do_reset();
    send(-8388608, 8388607);
    send(8388607, -8388608);
    repeat (16) @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL swing_drain got %0d left exp 0", sb.size()); end
    checks++; if ($signed(bus.out_l) != 8388607)  begin errors++; $display("FAIL swing_end_l got %0d exp 8388607", $signed(bus.out_l)); end
    checks++; if ($signed(bus.out_r) != -8388608) begin errors++; $display("FAIL swing_end_r got %0d exp -8388608", $signed(bus.out_r)); end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int max_lvl = 0;
    do_reset();
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.s_valid = 1'b1;
      bus.s_l = 24'(idx * 64);
      bus.s_r = 24'(1000 - idx * 32);
      checks++;
      if (bus.s_ready !== (fifo_level != 3'd4)) begin
        errors++;
        $display("FAIL bp_ready got s_ready=%b exp %b at level %0d", bus.s_ready, fifo_level != 3'd4, fifo_level);
      end
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (bus.s_ready) begin
        model_push(idx * 64, 1000 - idx * 32);
        idx++;
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    checks++; if (max_lvl != DEPTH) begin errors++; $display("FAIL bp_max_level got %0d exp %0d", max_lvl, DEPTH); end
    repeat (40) @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_drain got %0d left exp 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    send(0, 0);
    send(400, 400);
    send(800, 800);
    while (!(bus.out_valid && $signed(bus.out_l) == 200) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 30) begin errors++; $display("FAIL mid_wait got no phase-2 output exp out_l=200"); end
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_l !== 24'd0 || bus.out_r !== 24'd0) begin errors++; $display("FAIL mid_out got %0d/%0d exp 0/0", bus.out_l, bus.out_r); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", fifo_level); end
    rst = 1'b0;
    @(negedge clk);
    send(100, -100);
    send(300, -300);
    repeat (14) @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL mid_drain got %0d left exp 0", sb.size()); end
    checks++; if ($signed(bus.out_l) != 300) begin errors++; $display("FAIL mid_restart_l got %0d exp 300", $signed(bus.out_l)); end
  endtask

  task automatic test_constant();
    do_reset();
    for (int i = 0; i < 2500; i++) send(1000, -1000);
    repeat (30) @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL const_drain got %0d left exp 0", sb.size()); end
    checks++; if ($signed(bus.out_l) != 1000)  begin errors++; $display("FAIL const_l got %0d exp 1000", $signed(bus.out_l)); end
    checks++; if ($signed(bus.out_r) != -1000) begin errors++; $display("FAIL const_r got %0d exp -1000", $signed(bus.out_r)); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish exp finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_l     = '0;
    bus.s_r     = '0;
    test_reset();
    test_ramp_hold();
    test_resume();
    test_full_swing();
    test_backpressure();
    test_reset_mid();
    test_constant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
